// File: rtl/fb_pkg.sv
// Shared constants, flag bundle and pixel helper for the framebuffer scanout slice.
package fb_pkg;
    localparam int FB_W    = 800;
    localparam int FB_H    = 600;
    localparam int FB_SIZE = FB_W * FB_H;

    localparam int SVGA_H_ACTIVE = FB_W;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = FB_H;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;

    localparam int FB_RD_LAT = 2;
    localparam int FB_ADDR_W = 20;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic first;
    } vid_flags_t;

    // Bit replication spreads each channel over the full 8-bit range.
    function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
    endfunction
endpackage

// File: rtl/framebuffer_scanout_if.sv
// Framebuffer read port: scanout is the master, the memory is the slave.
interface framebuffer_scanout_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
) ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;

    modport master (output mem_rd_en, output mem_addr, input mem_rd_data);
    modport slave  (input mem_rd_en, input mem_addr, output mem_rd_data);
endinterface

// File: rtl/framebuffer_scanout_timing.sv
// Horizontal/vertical raster counters with stage-0 decode of the visible
// area, sync windows, first pixel and last cycle of the frame.
module video_timing_gen
    import fb_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FP     = SVGA_H_FP,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BP     = SVGA_H_BP,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FP     = SVGA_V_FP,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BP     = SVGA_V_BP
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic active,
    output logic hs,
    output logic vs,
    output logic first_pixel,
    output logic frame_end
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          run;
    logic          h_last;
    logic          v_last;

    // Decode is suppressed during reset so the read strobe is quiet too.
    assign run    = en & ~rst;
    assign h_last = (h == HW'(HT - 1));
    assign v_last = (v == VW'(VT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (!en) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    assign active      = run && (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    assign hs          = run && (h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs          = run && (v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign first_pixel = run && (h == '0) && (v == '0);
    assign frame_end   = run && h_last && v_last;
endmodule

// File: rtl/framebuffer_scanout.sv
// Double-buffered RGB332 framebuffer scanout: address generation, buffer flip
// handshake, read-latency alignment and RGB888 expansion.
module framebuffer_scanout
    import fb_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FP     = SVGA_H_FP,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BP     = SVGA_H_BP,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FP     = SVGA_V_FP,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BP     = SVGA_V_BP,
    parameter int RD_LAT   = FB_RD_LAT,
    parameter int ADDR_W   = FB_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic                  buf_sel,
    framebuffer_scanout_if.master mem,
    output logic [7:0]            pix_r,
    output logic [7:0]            pix_g,
    output logic [7:0]            pix_b,
    output logic                  de,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start
);
    localparam logic [ADDR_W-1:0] BUF_SIZE = ADDR_W'(H_ACTIVE * V_ACTIVE);

    logic act0, hs0, vs0, first0, frame_end;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .active      (act0),
        .hs          (hs0),
        .vs          (vs0),
        .first_pixel (first0),
        .frame_end   (frame_end)
    );

    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] addr_hold;
    logic              next_buf;

    // frame_end is already gated by en, so a disabled scanout never flips.
    assign next_buf = buf_sel ^ (frame_end & swap_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_sel   <= 1'b0;
            swap_ack  <= 1'b0;
            rd_ptr    <= '0;
            addr_hold <= '0;
        end else begin
            swap_ack <= frame_end & swap_req;
            buf_sel  <= next_buf;
            if (!en || frame_end)
                rd_ptr <= next_buf ? BUF_SIZE : '0;
            else if (act0)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            if (act0)
                addr_hold <= rd_ptr;
        end
    end

    assign mem.mem_rd_en = act0;
    assign mem.mem_addr  = act0 ? rd_ptr : addr_hold;

    vid_flags_t flags0;
    vid_flags_t pipe [RD_LAT];

    assign flags0 = {act0, hs0, vs0, first0};

    // Flags ride alongside the memory read, then everything lands on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
        end else if (!en) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
        end else begin
            pipe[0] <= flags0;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
            de          <= pipe[RD_LAT-1].active;
            hsync       <= pipe[RD_LAT-1].hs;
            vsync       <= pipe[RD_LAT-1].vs;
            frame_start <= pipe[RD_LAT-1].first;
            {pix_r, pix_g, pix_b} <= pipe[RD_LAT-1].active ?
                                     rgb332_to_rgb888(mem.mem_rd_data) : 24'h0;
        end
    end
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout on a reduced raster (8x4 active).
module tb_framebuffer_scanout;
    localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int LAT = 2, AW = 20;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;
    localparam int BS = HA * VA;
    localparam int L  = LAT + 1;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0, swap_req = 1'b0;
    logic swap_ack, buf_sel, de, hsync, vsync, frame_start;
    logic [7:0] pix_r, pix_g, pix_b;

    framebuffer_scanout_if #(.ADDR_W(AW)) mem_if ();

    framebuffer_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .RD_LAT(LAT), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .swap_req(swap_req), .swap_ack(swap_ack),
        .buf_sel(buf_sel), .mem(mem_if), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Two-buffer memory with a fixed two-cycle read; idle reads return junk.
    logic [7:0] fbmem [0:2*BS-1];
    logic [7:0] rd_stage;
    always @(posedge clk) begin
        rd_stage <= (mem_if.mem_rd_en && mem_if.mem_addr < AW'(2*BS)) ?
                    fbmem[mem_if.mem_addr[5:0]] : 8'($urandom);
        mem_if.mem_rd_data <= rd_stage;
    end

    function automatic logic [23:0] expand(input logic [7:0] p);
        int r3 = int'(p[7:5]);
        int g3 = int'(p[4:2]);
        int b2 = int'(p[1:0]);
        return {8'((r3 * 255 + 3) / 7), 8'((g3 * 255 + 3) / 7), 8'(b2 * 85)};
    endfunction

    typedef struct { int due; logic [27:0] vid; } exp_t;
    exp_t exp_q[$];

    int   total = 0, bad = 0;
    int   cyc = 0, m_r = 0, m_last = 0;
    logic m_buf = 1'b0, m_ack = 1'b0;

    // Reference model: raster position since enable, buffer index, read address.
    initial begin : model
        int h, v, addr;
        bit act, hsx, vsx;
        forever begin
            @(posedge clk);
            if (rst) begin
                total++;
                if (mem_if.mem_rd_en !== 1'b0) begin
                    bad++;
                    $display("FAIL rd_en_in_reset: got %b want 0", mem_if.mem_rd_en);
                end
                m_r = 0; m_buf = 1'b0; m_ack = 1'b0; m_last = 0;
                exp_q.delete();
            end else if (!en) begin
                total++;
                if (mem_if.mem_rd_en !== 1'b0 || mem_if.mem_addr !== AW'(m_last)) begin
                    bad++;
                    $display("FAIL mem_idle: got en=%b addr=%0d want en=0 addr=%0d",
                             mem_if.mem_rd_en, mem_if.mem_addr, m_last);
                end
                m_r = 0; m_ack = 1'b0;
                exp_q.delete();
            end else begin
                h   = m_r % HT;
                v   = m_r / HT;
                act = (h < HA) && (v < VA);
                hsx = (h >= HA + HFP) && (h < HA + HFP + HS);
                vsx = (v >= VA + VFP) && (v < VA + VFP + VS);
                addr = 0;
                if (act) begin
                    addr   = (m_buf ? BS : 0) + v * HA + h;
                    m_last = addr;
                end
                total++;
                if (mem_if.mem_rd_en !== act || mem_if.mem_addr !== AW'(m_last)) begin
                    bad++;
                    $display("FAIL mem_read (h=%0d v=%0d): got en=%b addr=%0d want en=%b addr=%0d",
                             h, v, mem_if.mem_rd_en, mem_if.mem_addr, act, m_last);
                end
                exp_q.push_back('{due: cyc + L,
                                  vid: {act, hsx, vsx, (m_r == 0),
                                        act ? expand(fbmem[addr]) : 24'h0}});
                m_ack = (m_r == FT - 1) && swap_req;
                if (m_ack) m_buf = ~m_buf;
                m_r = (m_r + 1) % FT;
            end
            cyc++;
        end
    end

    // Monitor: pops the record due this cycle; with nothing due, video must be idle.
    initial begin : monitor
        logic [27:0] want, got;
        forever begin
            @(negedge clk);
            want = '0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) want = exp_q.pop_front().vid;
            got = {de, hsync, vsync, frame_start, pix_r, pix_g, pix_b};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL video @%0d: got de/hs/vs/fs=%b rgb=%h want %b rgb=%h",
                         cyc, got[27:24], got[23:0], want[27:24], want[23:0]);
            end
            total++;
            if ({swap_ack, buf_sel} !== {m_ack, m_buf}) begin
                bad++;
                $display("FAIL swap @%0d: got ack=%b buf=%b want ack=%b buf=%b",
                         cyc, swap_ack, buf_sel, m_ack, m_buf);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ack(input string tag, input int bound);
        int k = 0;
        while (swap_ack !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (swap_ack !== 1'b1) begin
            bad++;
            $display("FAIL %s: swap_ack got 0 want 1 within %0d cycles", tag, bound);
        end
    endtask

    task automatic wait_pos(input string tag, input int pos);
        int k = 0;
        while (m_r != pos && k < 2 * FT) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (m_r != pos) begin
            bad++;
            $display("FAIL %s: position got %0d want %0d", tag, m_r, pos);
        end
    endtask

    initial begin : stim
        int k;
        for (int i = 0; i < 2 * BS; i++) fbmem[i] = 8'($urandom);
        fbmem[0] = 8'hE3;
        fbmem[1] = 8'h1C;

        #2 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(100);

        // First frame from buffer 0: latency and the two known pixels.
        en = 1'b1;
        k = 0;
        while (frame_start !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k != L) begin
            bad++;
            $display("FAIL first_latency: got %0d want %0d", k, L);
        end
        total++;
        if ({pix_r, pix_g, pix_b} !== 24'hFF00FF) begin
            bad++;
            $display("FAIL pixel0: got %h want ff00ff", {pix_r, pix_g, pix_b});
        end
        tick(1);
        total++;
        if ({pix_r, pix_g, pix_b} !== 24'h00FF00) begin
            bad++;
            $display("FAIL pixel1: got %h want 00ff00", {pix_r, pix_g, pix_b});
        end
        tick(FT + 20);

        // Mid-frame request, dropped on the acknowledge.
        swap_req = 1'b1;
        wait_ack("swap_mid", 2 * FT);
        swap_req = 1'b0;
        tick(FT / 2);

        // Request raised only on the very last cycle of a frame.
        wait_pos("swap_last_pos", FT - 1);
        swap_req = 1'b1;
        tick(1);
        swap_req = 1'b0;
        total++;
        if (swap_ack !== 1'b1) begin
            bad++;
            $display("FAIL swap_last: swap_ack got %b want 1", swap_ack);
        end
        tick(FT / 3);

        // Held request flips at two consecutive frame ends.
        swap_req = 1'b1;
        wait_ack("swap_hold1", 2 * FT);
        tick(1);
        wait_ack("swap_hold2", 2 * FT);
        swap_req = 1'b0;
        tick(FT / 2);

        // Abort mid-line, then restart from the current buffer base.
        wait_pos("abort_pos", 2 * HT + 5);
        en = 1'b0;
        tick(3);
        en = 1'b1;
        tick(2 * FT);

        // Random requests and short enable drops.
        for (int i = 0; i < 1500; i++) begin
            swap_req = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 299) == 0) begin
                en = 1'b0;
                tick($urandom_range(1, 4));
                en = 1'b1;
            end
            tick(1);
        end
        swap_req = 1'b0;
        tick(FT);

        // Asynchronous reset mid-line while buffer 1 is displayed.
        if (m_buf == 1'b0) begin
            swap_req = 1'b1;
            wait_ack("swap_pre_reset", 2 * FT);
            swap_req = 1'b0;
        end
        wait_pos("reset_pos", HT + 4);
        #1 rst = 1'b1;
        #1;
        total++;
        if ({de, hsync, vsync, frame_start, pix_r, pix_g, pix_b, swap_ack, buf_sel} !== 30'h0) begin
            bad++;
            $display("FAIL async_reset: got de=%b rgb=%h ack=%b buf=%b want all 0",
                     de, {pix_r, pix_g, pix_b}, swap_ack, buf_sel);
        end
        tick(2);
        rst = 1'b0;
        tick(2 * FT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
